// File: rtl/trisc_ctrl_v3_if.sv
// Memory port of the TRISC control unit: request/direction/address-select out,
// ready back from the (variable-latency) memory.
interface trisc_ctrl_v3_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_rdy;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_rdy);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_rdy);
endinterface

// File: rtl/trisc_ctrl_v3.sv
// TRISC control FSM: handshaked fetch/decode/execute for the 8-opcode accumulator ISA,
// with a memory-stall watchdog (sticky ERR) and a retired-instruction counter.
module trisc_ctrl_v3 #(
  parameter int OPW     = 4,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4,
  parameter int CNT_W   = 16
)(
  input  logic             clk,
  input  logic             CLR,
  input  logic [OPW-1:0]   opcode,
  input  logic             acc_zero,
  trisc_ctrl_v3_if.master  mem,
  output logic             pc_clr,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             ir_load,
  output logic             acc_clr,
  output logic             acc_inc,
  output logic             acc_load,
  output logic             acc_src,
  output logic             alu_op,
  output logic             mdi_load,
  output logic             err,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,  S_FETCH = 4'd1, S_DECODE = 4'd2, S_INC   = 4'd3,
    S_CLRA   = 4'd4,  S_OPRD  = 4'd5, S_STPREP = 4'd6, S_WRITE = 4'd7,
    S_JUMP   = 4'd8,  S_ERR   = 4'd15
  } state_t;

  state_t          cur, nxt;
  logic [TO_W-1:0] stall;
  logic [2:0]      op;
  logic            is_nop, wait_st, timeout;

  // Any set bit above the 3-bit opcode field turns the instruction into a NOP.
  assign is_nop  = (opcode >> 3) != '0;
  assign op      = opcode[2:0];
  assign wait_st = cur inside {S_FETCH, S_OPRD, S_WRITE};
  assign timeout = (TIMEOUT != 0) && wait_st && !mem.mem_rdy && (stall == TO_W'(TIMEOUT));
  assign state   = cur;

  always_comb begin
    nxt          = cur;
    pc_clr       = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    ir_load      = 1'b0;
    acc_clr      = 1'b0;
    acc_inc      = 1'b0;
    acc_load     = 1'b0;
    acc_src      = 1'b0;
    alu_op       = 1'b0;
    mdi_load     = 1'b0;
    err          = 1'b0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    case (cur)
      S_RESET: begin
        pc_clr = 1'b1;
        nxt    = S_FETCH;
      end
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ir_load     = mem.mem_rdy;
        if (mem.mem_rdy) nxt = S_DECODE;
      end
      S_DECODE: begin
        pc_inc = 1'b1;
        if (is_nop) nxt = S_FETCH;
        else case (op)
          3'd0:             nxt = S_INC;
          3'd1:             nxt = S_CLRA;
          3'd3:             nxt = S_STPREP;
          3'd5:             nxt = S_JUMP;
          3'd7:             nxt = acc_zero ? S_JUMP : S_FETCH;
          default:          nxt = S_OPRD;
        endcase
      end
      S_INC: begin
        acc_inc = 1'b1;
        nxt     = S_FETCH;
      end
      S_CLRA: begin
        acc_clr = 1'b1;
        nxt     = S_FETCH;
      end
      S_OPRD: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = 1'b1;
        acc_src      = (op != 3'd2);
        alu_op       = (op == 3'd6);
        acc_load     = mem.mem_rdy;
        if (mem.mem_rdy) nxt = S_FETCH;
      end
      S_STPREP: begin
        mdi_load = 1'b1;
        nxt      = S_WRITE;
      end
      S_WRITE: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.addr_sel = 1'b1;
        if (mem.mem_rdy) nxt = S_FETCH;
      end
      S_JUMP: begin
        mem.addr_sel = 1'b1;
        pc_load      = 1'b1;
        nxt          = S_FETCH;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: nxt = S_RESET;
    endcase
    // A ready arriving in the last allowed cycle still completes normally.
    if (timeout) nxt = S_ERR;
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      cur     <= S_RESET;
      stall   <= '0;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        stall <= '0;
      else if (wait_st && !mem.mem_rdy)
        stall <= stall + 1'b1;
      if (nxt == S_FETCH &&
          cur inside {S_DECODE, S_INC, S_CLRA, S_OPRD, S_WRITE, S_JUMP})
        retired <= retired + 1'b1;
    end
  end
endmodule

// File: tb/tb_trisc_ctrl_v3.sv
// Randomized bench for trisc_ctrl_v3: instruction-level trace model vs two DUTs
// (16-bit and 4-bit retired counters) driven in lockstep.
module tb_trisc_ctrl_v3;
  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
  } cyc_t;

  logic clk = 1'b0, CLR = 1'b0, mem_rdy = 1'b0, acc_zero = 1'b0;
  logic [3:0] opcode = '0;
  int   vectors = 0, fails = 0;
  logic [31:0] n_done = '0;

  trisc_ctrl_v3_if m0();
  trisc_ctrl_v3_if m1();
  assign m0.mem_rdy = mem_rdy;
  assign m1.mem_rdy = mem_rdy;

  logic pc_clr, pc_inc, pc_load, ir_load, acc_clr, acc_inc, acc_load, acc_src, alu_op, mdi_load, err;
  logic [3:0]  state;
  logic [15:0] retired;
  logic b_pc_clr, b_pc_inc, b_pc_load, b_ir_load, b_acc_clr, b_acc_inc, b_acc_load, b_acc_src, b_alu_op, b_mdi_load, b_err;
  logic [3:0]  state2;
  logic [3:0]  retired4;
  logic [13:0] ctl, ctl2;

  assign ctl  = {m0.mem_req, m0.mem_we, m0.addr_sel, pc_clr, pc_inc, pc_load, ir_load,
                 acc_clr, acc_inc, acc_load, acc_src, alu_op, mdi_load, err};
  assign ctl2 = {m1.mem_req, m1.mem_we, m1.addr_sel, b_pc_clr, b_pc_inc, b_pc_load, b_ir_load,
                 b_acc_clr, b_acc_inc, b_acc_load, b_acc_src, b_alu_op, b_mdi_load, b_err};

  trisc_ctrl_v3 #(.OPW(4), .TIMEOUT(15), .TO_W(4), .CNT_W(16)) dut (
    .clk(clk), .CLR(CLR), .opcode(opcode), .acc_zero(acc_zero), .mem(m0.master),
    .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_load(pc_load), .ir_load(ir_load),
    .acc_clr(acc_clr), .acc_inc(acc_inc), .acc_load(acc_load), .acc_src(acc_src),
    .alu_op(alu_op), .mdi_load(mdi_load), .err(err), .state(state), .retired(retired));

  trisc_ctrl_v3 #(.OPW(4), .TIMEOUT(15), .TO_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .CLR(CLR), .opcode(opcode), .acc_zero(acc_zero), .mem(m1.master),
    .pc_clr(b_pc_clr), .pc_inc(b_pc_inc), .pc_load(b_pc_load), .ir_load(b_ir_load),
    .acc_clr(b_acc_clr), .acc_inc(b_acc_inc), .acc_load(b_acc_load), .acc_src(b_acc_src),
    .alu_op(b_alu_op), .mdi_load(b_mdi_load), .err(b_err), .state(state2), .retired(retired4));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Control word each state must present, straight from the state/output table.
  function automatic logic [13:0] exp_ctl(input logic [3:0] st, input logic [3:0] op, input logic rdy);
    logic [13:0] v;
    v = '0;
    case (st)
      4'd0:  v[10] = 1'b1;
      4'd1:  begin v[13] = 1'b1; v[7] = rdy; end
      4'd2:  v[9] = 1'b1;
      4'd3:  v[5] = 1'b1;
      4'd4:  v[6] = 1'b1;
      4'd5:  begin v[13] = 1'b1; v[11] = 1'b1; v[4] = rdy;
                   v[3] = (op == 4'd4 || op == 4'd6); v[2] = (op == 4'd6); end
      4'd6:  v[1] = 1'b1;
      4'd7:  begin v[13] = 1'b1; v[12] = 1'b1; v[11] = 1'b1; end
      4'd8:  begin v[11] = 1'b1; v[8] = 1'b1; end
      4'd15: v[0] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    CLR = 1'b1; mem_rdy = 1'b0;
    #1;
    vectors++; if (state !== 4'd0 || state2 !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d/%0d want 0", state, state2); end
    vectors++; if (ctl !== exp_ctl(4'd0, opcode, 1'b0)) begin fails++; $display("FAIL reset_ctl: got %b want %b", ctl, exp_ctl(4'd0, opcode, 1'b0)); end
    vectors++; if (retired !== 16'd0 || retired4 !== 4'd0) begin fails++; $display("FAIL reset_retired: got %0d/%0d want 0", retired, retired4); end
    @(negedge clk);
    CLR = 1'b0; n_done = '0;
    #1;
    vectors++; if (state !== 4'd0) begin fails++; $display("FAIL reset_hold: got %0d want 0", state); end
  endtask

  // Expands one instruction into its expected per-cycle state trace, drives it, checks every cycle.
  task automatic run_instr(input logic [3:0] op, input logic az, input int wf, input int wo);
    cyc_t q[$];
    logic [13:0] e;
    for (int i = 0; i < wf; i++) q.push_back('{4'd1, 1'b0});
    q.push_back('{4'd1, 1'b1});
    q.push_back('{4'd2, 1'($urandom)});
    if (op < 4'd8) begin
      case (op)
        4'd0: q.push_back('{4'd3, 1'($urandom)});
        4'd1: q.push_back('{4'd4, 1'($urandom)});
        4'd3: begin
          q.push_back('{4'd6, 1'($urandom)});
          for (int i = 0; i < wo; i++) q.push_back('{4'd7, 1'b0});
          q.push_back('{4'd7, 1'b1});
        end
        4'd5: q.push_back('{4'd8, 1'($urandom)});
        4'd7: if (az) q.push_back('{4'd8, 1'($urandom)});
        default: begin
          for (int i = 0; i < wo; i++) q.push_back('{4'd5, 1'b0});
          q.push_back('{4'd5, 1'b1});
        end
      endcase
    end
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin opcode = op; acc_zero = az; end
      mem_rdy = q[k].rdy;
      #1;
      e = exp_ctl(q[k].st, op, q[k].rdy);
      vectors++; if (state !== q[k].st) begin fails++; $display("FAIL op%0d_state c%0d: got %0d want %0d", op, k, state, q[k].st); end
      vectors++; if (state2 !== q[k].st) begin fails++; $display("FAIL op%0d_state4 c%0d: got %0d want %0d", op, k, state2, q[k].st); end
      vectors++; if (ctl !== e) begin fails++; $display("FAIL op%0d_ctl c%0d: got %b want %b", op, k, ctl, e); end
      vectors++; if (ctl2 !== e) begin fails++; $display("FAIL op%0d_ctl4 c%0d: got %b want %b", op, k, ctl2, e); end
      vectors++; if (retired !== n_done[15:0]) begin fails++; $display("FAIL op%0d_retired c%0d: got %0d want %0d", op, k, retired, n_done[15:0]); end
      vectors++; if (retired4 !== n_done[3:0]) begin fails++; $display("FAIL op%0d_retired4 c%0d: got %0d want %0d", op, k, retired4, n_done[3:0]); end
    end
    n_done++;
  endtask

  task automatic test_reset_inca();
    apply_reset();
    run_instr(4'd0, 1'b0, 0, 0);
    run_instr(4'd1, 1'b0, 0, 0);
  endtask

  task automatic test_lda_wait();
    run_instr(4'd2, 1'b0, 0, 3);
    run_instr(4'd4, 1'b0, 2, 1);
  endtask

  task automatic test_sub_sta();
    run_instr(4'd6, 1'b0, 0, 0);
    run_instr(4'd3, 1'b0, 1, 2);
    run_instr(4'd3, 1'b1, 0, 0);
  endtask

  task automatic test_jz_nop();
    run_instr(4'd7, 1'b1, 0, 0);
    run_instr(4'd7, 1'b0, 0, 0);
    run_instr(4'd8, 1'b1, 0, 0);
    run_instr(4'd5, 1'b0, 1, 0);
    run_instr(4'd15, 1'b0, 0, 0);
  endtask

  task automatic test_watchdog();
    apply_reset();
    run_instr(4'd0, 1'b0, 15, 0);
    run_instr(4'd2, 1'b0, 0, 15);
    run_instr(4'd3, 1'b0, 0, 15);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); mem_rdy = 1'b0; #1;
      vectors++; if (state !== 4'd1) begin fails++; $display("FAIL wd_stall c%0d: got %0d want 1", i, state); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_rdy = 1'($urandom); #1;
      vectors++; if (state !== 4'd15 || state2 !== 4'd15) begin fails++; $display("FAIL wd_err_state c%0d: got %0d/%0d want 15", i, state, state2); end
      vectors++; if (ctl !== exp_ctl(4'd15, opcode, 1'b0)) begin fails++; $display("FAIL wd_err_ctl c%0d: got %b want %b", i, ctl, exp_ctl(4'd15, opcode, 1'b0)); end
      vectors++; if (retired !== n_done[15:0]) begin fails++; $display("FAIL wd_retired c%0d: got %0d want %0d", i, retired, n_done[15:0]); end
    end
    apply_reset();
  endtask

  task automatic test_clr_mid_access();
    apply_reset();
    for (int i = 0; i < 3; i++) run_instr(4'd0, 1'b0, 0, 0);
    @(negedge clk); opcode = 4'd2; mem_rdy = 1'b1;
    @(negedge clk); mem_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    vectors++; if (state !== 4'd5 || m0.mem_req !== 1'b1) begin fails++; $display("FAIL clr_pre: got st%0d req%b want st5 req1", state, m0.mem_req); end
    #2; CLR = 1'b1; #1;
    vectors++; if (state !== 4'd0 || state2 !== 4'd0) begin fails++; $display("FAIL clr_async_state: got %0d/%0d want 0", state, state2); end
    vectors++; if (ctl !== exp_ctl(4'd0, opcode, 1'b0)) begin fails++; $display("FAIL clr_async_ctl: got %b want %b", ctl, exp_ctl(4'd0, opcode, 1'b0)); end
    vectors++; if (retired !== 16'd0 || retired4 !== 4'd0) begin fails++; $display("FAIL clr_async_retired: got %0d/%0d want 0", retired, retired4); end
    @(negedge clk); CLR = 1'b0; n_done = '0;
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    for (int i = 0; i < 17; i++) run_instr(4'd0, 1'b0, 0, 0);
    @(negedge clk); opcode = 4'd1; mem_rdy = 1'b0; #1;
    vectors++; if (retired4 !== 4'd1) begin fails++; $display("FAIL wrap_retired4: got %0d want 1", retired4); end
    vectors++; if (retired !== 16'd17) begin fails++; $display("FAIL wrap_retired: got %0d want 17", retired); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      run_instr(op, 1'($urandom),
                ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset_inca();
    test_lda_wait();
    test_sub_sta();
    test_jz_nop();
    test_watchdog();
    test_clr_mid_access();
    test_counter_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
